// File: rtl/keypad_pkg.sv
// keypad_pkg: sizing helpers and FSM encoding shared by the keypad scanner files.
package keypad_pkg;

   localparam int CNT_W = 4;

   typedef enum logic {
      ST_DRIVE  = 1'b0,
      ST_SAMPLE = 1'b1
   } state_t;

   function automatic int nkeys(input int rows, input int cols);
      return rows * cols;
   endfunction

   function automatic int key_w(input int rows, input int cols);
      return $clog2(rows * cols);
   endfunction

   // An event is {key index, press flag}.
   function automatic int evt_w(input int rows, input int cols);
      return key_w(rows, cols) + 1;
   endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: first-word fall-through event queue; a push into a full queue
// is accepted when a pop happens in the same cycle.
module keypad_evt_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int EVT_W      = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic [EVT_W-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic             empty,
   output logic [EVT_W-1:0] data
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [EVT_W-1:0] mem [FIFO_DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is forced to zero while empty so the outputs have a defined reset value.
   assign data    = empty ? '0 : mem[rd_q[AW-1:0]];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned matrix with time-multiplexed per-key debounce and event queue.
// Define KEYPAD_DROP_ON_FULL_EN to drop events on a full queue (adds OVERFLOW) instead of stalling.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYCLES  = 64,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   output logic [ROWS-1:0]              ROW_N,
   input  logic [COLS-1:0]              COL_N,
   output logic [ROWS*COLS-1:0]         KEYS,
   output logic                         EVT_VALID,
   input  logic                         EVT_READY,
   output logic [key_w(ROWS,COLS)-1:0]  EVT_KEY,
   output logic                         EVT_PRESS
`ifdef KEYPAD_DROP_ON_FULL_EN
   ,
   output logic                         OVERFLOW
`endif
);
   localparam int NKEYS = nkeys(ROWS, COLS);
   localparam int KEY_W = key_w(ROWS, COLS);
   localparam int EVT_W = evt_w(ROWS, COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int SET_W = $clog2(SETTLE_CYCLES);

   state_t                       state_q, state_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic [COL_W-1:0]             col_q, col_d;
   logic [SET_W-1:0]             settle_q, settle_d;
   logic [ROWS-1:0]              row_n_q;
   logic [COLS-1:0]              sync1_q, sync2_q;
   logic [NKEYS-1:0]             keys_q;
   logic [NKEYS-1:0][CNT_W-1:0]  cnt_q;
   logic [KEY_W-1:0]             k;
   logic                         sample, differs, flip, room, push, stall;
   logic                         fifo_full, fifo_empty;
   logic [EVT_W-1:0]             fifo_data;

   assign k       = KEY_W'(int'(row_q) * COLS + int'(col_q));
   assign sample  = ~sync2_q[col_q];
   assign differs = (state_q == ST_SAMPLE) && (sample != keys_q[k]);
   assign flip    = differs && (cnt_q[k] == CNT_W'(DEBOUNCE_SCANS - 1));
   // A simultaneous pop frees the slot this push needs.
   assign room    = !fifo_full || EVT_READY;
   assign push    = flip && room;

`ifdef KEYPAD_DROP_ON_FULL_EN
   logic ovf_q;

   assign stall    = 1'b0;
   assign OVERFLOW = ovf_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)             ovf_q <= 1'b0;
      else if (flip && !room) ovf_q <= 1'b1;
   end
`else
   assign stall = flip && !room;
`endif

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      settle_d = settle_q;
      case (state_q)
         ST_DRIVE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d  = ST_SAMPLE;
               col_d    = '0;
               settle_d = '0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (!stall) begin
               if (col_q == COL_W'(COLS - 1)) begin
                  state_d = ST_DRIVE;
                  row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         default: state_d = ST_DRIVE;
      endcase
   end

   // Row drive is registered so reset can hold every row released.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_DRIVE;
         row_q    <= '0;
         col_q    <= '0;
         settle_q <= '0;
         row_n_q  <= '1;
         sync1_q  <= '1;
         sync2_q  <= '1;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         settle_q <= settle_d;
         row_n_q  <= ~(ROWS'(1) << row_d);
         sync1_q  <= COL_N;
         sync2_q  <= sync1_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         keys_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == ST_SAMPLE && !stall) begin
         if (!differs) begin
            cnt_q[k] <= '0;
         end else if (flip) begin
            keys_q[k] <= sample;
            cnt_q[k]  <= '0;
         end else begin
            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
         end
      end
   end

   keypad_evt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .EVT_W      (EVT_W)
   ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push),
      .push_data ({k, sample}),
      .full      (fifo_full),
      .pop       (EVT_READY),
      .empty     (fifo_empty),
      .data      (fifo_data)
   );

   assign ROW_N     = row_n_q;
   assign KEYS      = keys_q;
   assign EVT_VALID = !fifo_empty;
   assign EVT_KEY   = fifo_data[EVT_W-1:1];
   assign EVT_PRESS = fifo_data[0];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized scan-level checks of keypad_scanner
// against a per-scan debounce history model and a physical key-matrix model.
module tb_keypad_scanner;
   localparam int ROWS = 2, COLS = 2, SETTLE = 3, DEB = 3, DEPTH = 2;
   localparam int NK = ROWS * COLS;
   localparam int KW = $clog2(NK);
   localparam logic [ROWS-1:0] ROW0 = 2'b10, ROW1 = 2'b01, NOROW = 2'b11;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [ROWS-1:0] ROW_N;
   logic [COLS-1:0] COL_N;
   logic [NK-1:0]   KEYS;
   logic            EVT_VALID, EVT_PRESS, evt_ready;
   logic [KW-1:0]   EVT_KEY;
`ifdef KEYPAD_DROP_ON_FULL_EN
   logic            OVERFLOW;
`endif

   logic [NK-1:0]          pressed;
   logic                   rdy_fix, rdy_rnd, rdy_rand_en;
   int                     n_vec, n_bad;
   logic [NK-1:0]          mkeys;
   logic [NK-1:0][DEB-1:0] hist;
   logic [KW:0]            exp_q[$];
   logic [KW:0]            got_q[$];

   always #5 CLK = ~CLK;

   assign evt_ready = rdy_rand_en ? rdy_rnd : rdy_fix;
   always @(posedge CLK) rdy_rnd <= 1'($urandom_range(1));

   // Switch matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      COL_N = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!ROW_N[r] && pressed[r*COLS+c]) COL_N[c] = 1'b0;
   end

   always @(negedge CLK)
      if (RST_N && EVT_VALID && evt_ready) got_q.push_back({EVT_KEY, EVT_PRESS});

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
      .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .ROW_N(ROW_N), .COL_N(COL_N), .KEYS(KEYS),
      .EVT_VALID(EVT_VALID), .EVT_READY(evt_ready), .EVT_KEY(EVT_KEY),
      .EVT_PRESS(EVT_PRESS)
`ifdef KEYPAD_DROP_ON_FULL_EN
      , .OVERFLOW(OVERFLOW)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Waits for the edge where row 0 becomes driven, i.e. the start of a scan.
   task automatic wait_row0(output int cycles);
      logic [ROWS-1:0] prev;
      logic            found;
      prev = ROW_N;
      found = 1'b0;
      cycles = 0;
      while (!found && cycles < 200) begin
         @(posedge CLK); #1;
         cycles++;
         found = (ROW_N == ROW0) && (prev != ROW0);
         prev = ROW_N;
      end
      chk("row0_start", 32'(found), 32'(1));
   endtask

   task automatic align();
      int c;
      wait_row0(c);
   endtask

   // A key flips once its last DEB scan samples all equal a value other than its stable state.
   task automatic model_update(input logic [NK-1:0] pat);
      for (int k = 0; k < NK; k++) begin
         hist[k] = {hist[k][DEB-2:0], pat[k]};
         if (pat[k] != mkeys[k] && hist[k] == {DEB{pat[k]}}) begin
            mkeys[k] = pat[k];
            exp_q.push_back({KW'(k), pat[k]});
         end
      end
   endtask

   task automatic do_scan(input logic [NK-1:0] pat);
      int c;
      pressed = pat;
      wait_row0(c);
      model_update(pat);
      chk("keys", 32'(KEYS), 32'(mkeys));
   endtask

   task automatic check_events(input string tag);
      int waited;
      waited = 0;
      rdy_rand_en = 1'b0;
      rdy_fix = 1'b1;
      while (got_q.size() < exp_q.size() && waited < 200) begin
         @(posedge CLK); #1;
         waited++;
      end
      repeat (5) @(posedge CLK);
      #1;
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      int            cyc;
      logic [NK-1:0] pat;
      n_vec = 0;
      n_bad = 0;
      pressed = '0;
      rdy_fix = 1'b1;
      rdy_rand_en = 1'b0;
      mkeys = '0;
      hist = '0;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_row_n", 32'(ROW_N), 32'(NOROW));
      chk("rst_keys", 32'(KEYS), 32'(0));
      chk("rst_valid", 32'(EVT_VALID), 32'(0));
      chk("rst_key", 32'(EVT_KEY), 32'(0));
      chk("rst_press", 32'(EVT_PRESS), 32'(0));
`ifdef KEYPAD_DROP_ON_FULL_EN
      chk("rst_ovf", 32'(OVERFLOW), 32'(0));
`endif
      RST_N = 1'b1;

      // Idle scan: 5 cycles per row, 10 per scan.
      cyc = 0;
      while (ROW_N != ROW1 && cyc < 50) begin
         @(posedge CLK); #1;
         cyc++;
      end
      chk("idle_row1_seen", 32'(ROW_N), 32'(ROW1));
      for (int i = 0; i < 20; i++) begin
         chk("idle_row_n", 32'(ROW_N), 32'(((i % 10) < 5) ? ROW1 : ROW0));
         @(posedge CLK); #1;
      end
      chk("idle_keys", 32'(KEYS), 32'(0));
      chk("idle_valid", 32'(EVT_VALID), 32'(0));

      // Clean press and release of key 3.
      align();
      repeat (3) do_scan(4'b1000);
      repeat (3) do_scan(4'b0000);
      check_events("press3");

      // Bounce on key 0.
      align();
      repeat (2) do_scan(4'b0001);
      do_scan(4'b0000);
      repeat (3) do_scan(4'b0001);
      repeat (3) do_scan(4'b0000);
      check_events("bounce");

      // Backpressure: keys 0, 1, 2 with the consumer stalled.
      align();
      rdy_fix = 1'b0;
      repeat (2) do_scan(4'b0111);
      pressed = 4'b0111;
`ifdef KEYPAD_DROP_ON_FULL_EN
      wait_row0(cyc);
      chk("drop_scan_period", 32'(cyc), 32'(10));
      model_update(4'b0111);
      void'(exp_q.pop_back());
      chk("drop_ovf", 32'(OVERFLOW), 32'(1));
      chk("drop_keys", 32'(KEYS), 32'(mkeys));
      chk("drop_head_key", 32'(EVT_KEY), 32'(0));
`else
      repeat (15) @(posedge CLK);
      #1;
      chk("stall_row_n", 32'(ROW_N), 32'(ROW1));
      chk("stall_keys", 32'(KEYS), 32'(4'b0011));
      chk("stall_valid", 32'(EVT_VALID), 32'(1));
      chk("stall_head_key", 32'(EVT_KEY), 32'(0));
      chk("stall_head_press", 32'(EVT_PRESS), 32'(1));
      rdy_fix = 1'b1;
      wait_row0(cyc);
      model_update(4'b0111);
      chk("bp_keys", 32'(KEYS), 32'(mkeys));
`endif
      check_events("backpressure");
      align();
      repeat (3) do_scan(4'b0000);
      check_events("bp_release");

      // Reset while sampling with one event queued.
      align();
      rdy_fix = 1'b0;
      repeat (3) do_scan(4'b0001);
      repeat (3) @(posedge CLK);
      #1;
      chk("pre_rst_valid", 32'(EVT_VALID), 32'(1));
      RST_N = 1'b0;
      #1;
      chk("midrst_row_n", 32'(ROW_N), 32'(NOROW));
      chk("midrst_valid", 32'(EVT_VALID), 32'(0));
      chk("midrst_keys", 32'(KEYS), 32'(0));
      pressed = '0;
      mkeys = '0;
      hist = '0;
      exp_q.delete();
      got_q.delete();
      rdy_fix = 1'b1;
      @(posedge CLK); #2;
      RST_N = 1'b1;
      chk("rel_keys", 32'(KEYS), 32'(0));
      chk("rel_valid", 32'(EVT_VALID), 32'(0));
      @(posedge CLK); #1;
      chk("rel_row0", 32'(ROW_N), 32'(ROW0));

      // Randomized key activity.
      align();
`ifndef KEYPAD_DROP_ON_FULL_EN
      rdy_rand_en = 1'b1;
`endif
      pat = '0;
      for (int s = 0; s < 40; s++) begin
         for (int k = 0; k < NK; k++)
            if ($urandom_range(3) == 0) pat[k] = ~pat[k];
         do_scan(pat);
      end
      repeat (DEB) do_scan(4'b0000);
      check_events("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
